mmio_ctrl: RTL

//  Memory-mapped I/O controller in the X/M stage, downstream of the X/M control logic.
//  - Decodes MMIO loads/stores from the ALU address (Addr[31]=1).
//  - Buffers one TX byte and one RX byte for the UART.
//  - Holds four performance counters: cycles, instructions, branches, taken branches.
//  - Returns load data registered, so it lands in the W stage alongside DMEM/BIOS data.

---
 rtl/mmio_pkg.sv | 20 ++
 rtl/mmio_ctrl_perf_counter.sv | 35 +++
 rtl/mmio_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// MMIO window constants shared by the X/M-stage I/O controller.
// Register offsets and ctrl status bit positions.
package mmio_pkg;

  localparam logic [31:0] MMIO_BASE_DEF = 32'h8000_0000;

  localparam logic [7:0] OFF_CTRL = 8'h00;
  localparam logic [7:0] OFF_RX   = 8'h04;
  localparam logic [7:0] OFF_TX   = 8'h08;
  localparam logic [7:0] OFF_CYC  = 8'h10;
  localparam logic [7:0] OFF_INST = 8'h14;
  localparam logic [7:0] OFF_CLR  = 8'h18;
  localparam logic [7:0] OFF_BR   = 8'h1C;
  localparam logic [7:0] OFF_BRT  = 8'h20;

  localparam int CTRL_TXRDY  = 0;
  localparam int CTRL_RXFULL = 1;
  localparam int CTRL_TXOVF  = 2;

endpackage

// File: rtl/mmio_ctrl_perf_counter.sv
// Free-running event counter with synchronous clear.
// Clear has priority over the increment in the same cycle.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mmio_ctrl.sv
// MMIO controller in X/M: UART byte buffers, perf counters,
// and registered load data that lands in W.
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int                W_SIZE    = 32,
  parameter logic [W_SIZE-1:0] MMIO_BASE = W_SIZE'(MMIO_BASE_DEF),
  parameter int                CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W_SIZE-1:0] mmio_addr,
  input  logic [W_SIZE-1:0] mmio_wdata,
  input  logic              mmio_we,
  input  logic              mmio_re,
  input  logic              inst_retire,
  input  logic              is_branch,
  input  logic              br_taken,
  output logic [7:0]        uart_tx_data,
  output logic              uart_tx_valid,
  input  logic              uart_tx_ready,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_valid,
  output logic              uart_rx_ready,
  output logic [W_SIZE-1:0] mmio_rdata
);

  logic [W_SIZE-1:0] off;
  logic              in_win;
  logic [7:0]        sel;

  logic              tx_full_q, tx_full_d;
  logic              tx_ovf_q, tx_ovf_d;
  logic [7:0]        tx_buf_q, tx_buf_d;
  logic              rx_full_q, rx_full_d;
  logic [7:0]        rx_buf_q, rx_buf_d;
  logic [W_SIZE-1:0] rdata_q, rdata_d;

  logic              wr_tx, wr_clr, rd_ctrl, rd_rx;
  logic              tx_acc, tx_drain, rx_take;
  logic [W_SIZE-1:0] ctrl_word;

  logic [CNT_W-1:0]  cyc_cnt, inst_cnt, br_cnt, brt_cnt;

  assign off    = mmio_addr - MMIO_BASE;
  assign in_win = (off[W_SIZE-1:8] == '0);
  assign sel    = off[7:0];

  assign wr_tx   = mmio_we & in_win & (sel == OFF_TX);
  assign wr_clr  = mmio_we & in_win & (sel == OFF_CLR);
  assign rd_ctrl = mmio_re & in_win & (sel == OFF_CTRL);
  assign rd_rx   = mmio_re & in_win & (sel == OFF_RX);

  assign tx_drain = tx_full_q & uart_tx_ready;
  assign tx_acc   = wr_tx & (~tx_full_q | uart_tx_ready);
  assign rx_take  = uart_rx_valid & ~rx_full_q;

  always_comb begin
    ctrl_word              = '0;
    ctrl_word[CTRL_TXRDY]  = ~tx_full_q;
    ctrl_word[CTRL_RXFULL] = rx_full_q;
    ctrl_word[CTRL_TXOVF]  = tx_ovf_q;
  end

  always_comb begin
    tx_full_d = tx_full_q;
    tx_buf_d  = tx_buf_q;
    tx_ovf_d  = tx_ovf_q;
    if (tx_acc) begin
      tx_full_d = 1'b1;
      tx_buf_d  = mmio_wdata[7:0];
    end else if (tx_drain) begin
      tx_full_d = 1'b0;
    end
    // a dropped store outranks the clear-on-read
    if (wr_tx & ~tx_acc) begin
      tx_ovf_d = 1'b1;
    end else if (rd_ctrl) begin
      tx_ovf_d = 1'b0;
    end
  end

  always_comb begin
    rx_full_d = rx_full_q;
    rx_buf_d  = rx_buf_q;
    if (rx_take) begin
      rx_full_d = 1'b1;
      rx_buf_d  = uart_rx_data;
    end else if (rd_rx) begin
      rx_full_d = 1'b0;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (mmio_re) begin
      rdata_d = '0;
      if (in_win) begin
        case (sel)
          OFF_CTRL: rdata_d = ctrl_word;
          OFF_RX:   rdata_d = W_SIZE'(rx_buf_q);
          OFF_CYC:  rdata_d = W_SIZE'(cyc_cnt);
          OFF_INST: rdata_d = W_SIZE'(inst_cnt);
          OFF_BR:   rdata_d = W_SIZE'(br_cnt);
          OFF_BRT:  rdata_d = W_SIZE'(brt_cnt);
          default:  rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_full_q <= 1'b0;
      tx_ovf_q  <= 1'b0;
      tx_buf_q  <= '0;
      rx_full_q <= 1'b0;
      rx_buf_q  <= '0;
      rdata_q   <= '0;
    end else begin
      tx_full_q <= tx_full_d;
      tx_ovf_q  <= tx_ovf_d;
      tx_buf_q  <= tx_buf_d;
      rx_full_q <= rx_full_d;
      rx_buf_q  <= rx_buf_d;
      rdata_q   <= rdata_d;
    end
  end

  perf_counter #(.CNT_W(CNT_W)) u_cyc (
    .clk(clk), .rst_n(rst_n), .clr(wr_clr),
    .en(1'b1), .count(cyc_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_inst (
    .clk(clk), .rst_n(rst_n), .clr(wr_clr),
    .en(inst_retire), .count(inst_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_br (
    .clk(clk), .rst_n(rst_n), .clr(wr_clr),
    .en(inst_retire & is_branch), .count(br_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_brt (
    .clk(clk), .rst_n(rst_n), .clr(wr_clr),
    .en(inst_retire & is_branch & br_taken), .count(brt_cnt)
  );

  assign uart_tx_valid = tx_full_q;
  assign uart_tx_data  = tx_buf_q;
  assign uart_rx_ready = ~rx_full_q;
  assign mmio_rdata    = rdata_q;

endmodule
